// File: rtl/gpr_arb_pkg.sv
// Shared types and constants for the register-bank write arbiter.
// GPR_ARB_INIT_EN selects the post-reset clear sequence.
package gpr_arb_pkg;

  typedef enum logic {
    INIT,
    ARB
  } state_t;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;
  localparam int NUM_REGS   = 2 ** ADDR_W_DEF;

  localparam logic [ADDR_W_DEF-1:0] R0_ADDR = '0;

endpackage

// File: rtl/gpr_write_arbiter_rr_pick.sv
// Combinational round-robin pick: first eligible index
// at or after the pointer, wrapping.
module rr_pick
  import gpr_arb_pkg::*;
#(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  elig,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic          valid
);

  always_comb begin
    win   = '0;
    valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!valid && elig[(int'(ptr) + k) % N]) begin
        win[(int'(ptr) + k) % N] = 1'b1;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gpr_write_arbiter.sv
// Write-port sequencer/arbiter for the 32x32 GPR bank.
// GPR_ARB_INIT_EN compiles in the post-reset clear of all registers.
module gpr_write_arbiter
  import gpr_arb_pkg::*;
#(
  parameter int NREQ   = 3,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        gnt,
  output logic                   regWrite,
  output logic [ADDR_W-1:0]      write_register,
  output logic [DATA_W-1:0]      w_data,
  output logic                   busy
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]     ptr;
  logic [PW-1:0]     ptr_nxt;
  logic [NREQ-1:0]   elig;
  logic [NREQ-1:0]   win;
  logic              valid;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] data_sel;

  // a requester still seeing its grant is not yet eligible again
  assign elig = req & ~gnt;

  rr_pick #(
    .N  (NREQ),
    .PW (PW)
  ) u_pick (
    .elig  (elig),
    .ptr   (ptr),
    .win   (win),
    .valid (valid)
  );

  always_comb begin
    addr_sel = '0;
    data_sel = '0;
    ptr_nxt  = ptr;
    for (int i = 0; i < NREQ; i++) begin
      if (win[i]) begin
        addr_sel = req_addr[i*ADDR_W +: ADDR_W];
        data_sel = req_data[i*DATA_W +: DATA_W];
        ptr_nxt  = (i == NREQ - 1) ? '0 : PW'(i + 1);
      end
    end
  end

`ifdef GPR_ARB_INIT_EN
  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] clr_cnt;

  always_ff @(posedge clk) begin
    if (!reset) state <= INIT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == INIT && clr_cnt == '1)
      state_nxt = ARB;
  end

  always_ff @(posedge clk) begin
    if (!reset)             clr_cnt <= '0;
    else if (state == INIT) clr_cnt <= clr_cnt + 1'b1;
  end

  assign busy = (state == INIT);
`else
  assign busy = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      gnt            <= '0;
      regWrite       <= 1'b0;
      write_register <= '0;
      w_data         <= '0;
      ptr            <= '0;
    end
`ifdef GPR_ARB_INIT_EN
    else if (state == INIT) begin
      gnt            <= '0;
      regWrite       <= 1'b1;
      write_register <= clr_cnt;
      w_data         <= '0;
    end
`endif
    else if (valid) begin
      gnt            <= win;
      regWrite       <= (addr_sel != ADDR_W'(R0_ADDR));
      write_register <= addr_sel;
      w_data         <= data_sel;
      ptr            <= ptr_nxt;
    end else begin
      gnt      <= '0;
      regWrite <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gpr_write_arbiter.sv
// Scoreboard bench for gpr_write_arbiter; follows GPR_ARB_INIT_EN
// of the build for the clear-sequence checks.
module tb_gpr_write_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic [NREQ-1:0] gnt;
  logic            regWrite;
  logic [AW-1:0]   write_register;
  logic [DW-1:0]   w_data;
  logic            busy;

  gpr_write_arbiter #(
    .NREQ   (NREQ),
    .DATA_W (DW),
    .ADDR_W (AW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req            (req),
    .req_addr       (req_addr),
    .req_data       (req_data),
    .gnt            (gnt),
    .regWrite       (regWrite),
    .write_register (write_register),
    .w_data         (w_data),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NREQ-1:0] g;
    logic            rw;
    logic [AW-1:0]   a;
    logic [DW-1:0]   d;
    logic            bcare;
    logic            b;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;

`ifdef GPR_ARB_INIT_EN
  localparam logic BUSY_RST = 1'b1;
`else
  localparam logic BUSY_RST = 1'b0;
`endif

  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en && (gnt != '0 || regWrite)) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got gnt=%b rw=%b addr=%0d data=%h, required no write",
                 gnt, regWrite, write_register, w_data);
      end else begin
        e = q.pop_front();
        if (gnt !== e.g || regWrite !== e.rw || write_register !== e.a ||
            w_data !== e.d || (e.bcare && busy !== e.b)) begin
          errors++;
          $display("FAIL write: got gnt=%b rw=%b addr=%0d data=%h busy=%b, required gnt=%b rw=%b addr=%0d data=%h busy=%b",
                   gnt, regWrite, write_register, w_data, busy,
                   e.g, e.rw, e.a, e.d, e.b);
        end
      end
    end
  end

  task automatic push(input logic [NREQ-1:0] g, input logic rw,
                      input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic bcare, input logic b);
    exp_t e;
    e.g = g; e.rw = rw; e.a = a; e.d = d; e.bcare = bcare; e.b = b;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [DW-1:0] got,
                     input logic [DW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req[i] = 1'b1;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req   = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_gnt", DW'(gnt), '0);
    chk("rst_regwrite", DW'(regWrite), '0);
    chk("rst_addr", DW'(write_register), '0);
    chk("rst_data", w_data, '0);
    chk("rst_busy", DW'(busy), DW'(BUSY_RST));
    mon_en = 1'b1;
    reset  = 1'b1;
`ifdef GPR_ARB_INIT_EN
    for (int i = 0; i < 32; i++)
      push('0, 1'b1, AW'(i), '0, i < 31, 1'b1);
    repeat (32) @(posedge clk);
    #1;
    chk("busy_after_clear", DW'(busy), '0);
`endif
  endtask

  logic [DW-1:0] d [NREQ];

  initial begin
`ifdef GPR_ARB_INIT_EN
    // clear aborted after 10 writes, then restarted from address 0
    reset = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    reset  = 1'b1;
    for (int i = 0; i < 10; i++)
      push('0, 1'b1, AW'(i), '0, 1'b1, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    chk("midinit_addr", DW'(write_register), 32'd9);
    do_reset();
`else
    do_reset();
    set_req(0, 5'd3, 32'h0000_0011);
    push(3'b001, 1'b1, 5'd3, 32'h0000_0011, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    req = '0;
    chk("first_cycle_busy", DW'(busy), '0);
    repeat (2) @(posedge clk);
    #1;
`endif

    // single requester, held one cycle past its grant
    do_reset();
    set_req(1, 5'd7, 32'hDEAD_BEEF);
    push(3'b010, 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b1, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("no_regrant", DW'(gnt), '0);
    req = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("hold_addr", DW'(write_register), 32'd7);
    chk("hold_data", w_data, 32'hDEAD_BEEF);

    // r0 target: grant issued, bank write suppressed
    set_req(2, 5'd0, 32'h0000_1234);
    push(3'b100, 1'b0, 5'd0, 32'h0000_1234, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    req = '0;
    repeat (2) @(posedge clk);
    #1;

    // all three held; each re-requests with fresh data after its grant
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      d[i] = 32'hA000_0000 + DW'(i);
      set_req(i, AW'(i + 4), d[i]);
    end
    for (int n = 0; n < 6; n++) begin
      push(NREQ'(1 << (n % NREQ)), 1'b1, AW'((n % NREQ) + 4),
           d[n % NREQ], 1'b1, 1'b0);
      @(posedge clk);
      #1;
      d[n % NREQ] = d[n % NREQ] + 32'h10;
      set_req(n % NREQ, AW'((n % NREQ) + 4), d[n % NREQ]);
    end
    req = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drain", DW'(q.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
